// File: rtl/dram_write_buffer.sv
// Write-back buffer between the accelerator DRAM write port and a
// valid/ready memory port. A small FWFT queue absorbs write bursts; a small
// FSM tracks layer completion and flags dropped or late words.
module dram_write_buffer #(
   parameter int unsigned DEPTH           = 8,
   parameter int unsigned EXPECTED_WRITES = 64
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        DRAMwriteEn,
   input  logic [9:0]  DRAMwriteAddr,
   input  logic [63:0] DRAMwriteData,
   output logic        memValid,
   output logic [9:0]  memAddr,
   output logic [63:0] memData,
   input  logic        memReady,
   output logic [9:0]  writeCount,
   output logic        done,
   output logic        overflow,
   output logic        lateWrite
);

   localparam int unsigned AW = 10;
   localparam int unsigned DW = 64;
   localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned OW = PW + 1;
   localparam int unsigned CW = 10;

   typedef struct packed {
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
   } entry_t;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACTIVE = 2'd1,
      DONE   = 2'd2
   } state_t;

   entry_t        mem [DEPTH];
   logic [PW-1:0] rd_ptr;
   logic [PW-1:0] wr_ptr;
   logic [OW-1:0] occ;
   logic [OW-1:0] occ_next;
   logic [CW-1:0] count;
   logic [CW-1:0] count_next;
   logic          valid_q;
   logic          done_q;
   logic          overflow_q;
   logic          late_q;
   logic          push;
   logic          pop;
   state_t        state;
   state_t        state_next;

   // Handshake decode, occupancy and completed-write count for this cycle.
   always_comb begin
      pop        = valid_q & memReady;
      push       = DRAMwriteEn & ((occ < OW'(DEPTH)) | pop) & (state != DONE);
      occ_next   = occ;
      count_next = count;
      if (push && !pop) begin
         occ_next = occ + OW'(1);
      end else if (pop && !push) begin
         occ_next = occ - OW'(1);
      end
      if (pop && (count != {CW{1'b1}})) begin
         count_next = count + CW'(1);
      end
   end

   // Next-state logic: first accepted word starts the layer, the pop that
   // completes the expected count ends it.
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (push) state_next = ACTIVE;
         ACTIVE:  if (pop && (count_next == CW'(EXPECTED_WRITES))) state_next = DONE;
         DONE:    state_next = DONE;
         default: state_next = IDLE;
      endcase
   end

   // State, pointers, counters and sticky flags.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         rd_ptr     <= '0;
         wr_ptr     <= '0;
         occ        <= '0;
         count      <= '0;
         valid_q    <= 1'b0;
         done_q     <= 1'b0;
         overflow_q <= 1'b0;
         late_q     <= 1'b0;
      end else begin
         state   <= state_next;
         occ     <= occ_next;
         count   <= count_next;
         valid_q <= (occ_next != '0);
         done_q  <= (state_next == DONE);
         if (push) wr_ptr <= wr_ptr + PW'(1);
         if (pop)  rd_ptr <= rd_ptr + PW'(1);
         if (DRAMwriteEn && !push && (state != DONE)) overflow_q <= 1'b1;
         if (DRAMwriteEn && (state == DONE))          late_q     <= 1'b1;
      end
   end

   // Entry storage; a reset flushes by clearing pointers, not contents.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= '{addr: DRAMwriteAddr, data: DRAMwriteData};
      end
   end

   assign memValid   = valid_q;
   assign memAddr    = mem[rd_ptr].addr;
   assign memData    = mem[rd_ptr].data;
   assign writeCount = count;
   assign done       = done_q;
   assign overflow   = overflow_q;
   assign lateWrite  = late_q;

endmodule

// File: tb/tb_dram_write_buffer.sv
// Scoreboard bench for dram_write_buffer: stimulus queues expected memory
// transfers, a negedge monitor retires them against the memory port.
module tb_dram_write_buffer;

   localparam int unsigned EXP = 64;

   typedef struct packed {
      logic [9:0]  a;
      logic [63:0] d;
   } ent_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        DRAMwriteEn = 1'b0;
   logic [9:0]  DRAMwriteAddr = '0;
   logic [63:0] DRAMwriteData = '0;
   logic        memValid;
   logic [9:0]  memAddr;
   logic [63:0] memData;
   logic        memReady = 1'b0;
   logic [9:0]  writeCount;
   logic        done;
   logic        overflow;
   logic        lateWrite;

   ent_t sb[$];
   int   n_chk = 0;
   int   n_pass = 0;
   int   cnt_model = 0;
   bit   popped_prev = 0;
   bit   rnd_on = 0;

   dram_write_buffer #(.DEPTH(8), .EXPECTED_WRITES(EXP)) u_dut (
      .clk(clk), .rst(rst),
      .DRAMwriteEn(DRAMwriteEn), .DRAMwriteAddr(DRAMwriteAddr), .DRAMwriteData(DRAMwriteData),
      .memValid(memValid), .memAddr(memAddr), .memData(memData), .memReady(memReady),
      .writeCount(writeCount), .done(done), .overflow(overflow), .lateWrite(lateWrite)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wr(input logic [9:0] a, input logic [63:0] d, input bit acc);
      DRAMwriteEn   = 1'b1;
      DRAMwriteAddr = a;
      DRAMwriteData = d;
      if (acc) sb.push_back('{a: a, d: d});
      @(posedge clk);
      #1;
      DRAMwriteEn = 1'b0;
   endtask

   task automatic do_reset();
      memReady    = 1'b0;
      DRAMwriteEn = 1'b0;
      idle(1);
      rst = 1'b1;
      idle(1);
      rst = 1'b0;
      sb.delete();
      cnt_model = 0;
   endtask

   // Monitor: retire each transfer the memory accepts and check count/done after it.
   always @(negedge clk) begin
      if (rst) begin
         popped_prev = 0;
      end else begin
         if (popped_prev) begin
            check("pop_count", 64'(writeCount), 64'(cnt_model));
            check("done_edge", 64'(done), 64'(cnt_model >= int'(EXP)));
         end
         popped_prev = 0;
         if (memValid && memReady) begin
            check("sb_has_entry", 64'(sb.size() != 0), 64'd1);
            if (sb.size() != 0) begin
               check("mem_addr", 64'(memAddr), 64'(sb[0].a));
               check("mem_data", memData, sb[0].d);
               void'(sb.pop_front());
               cnt_model++;
               popped_prev = 1;
            end
         end
      end
   end

   // Random 50% memReady while enabled.
   initial begin
      forever begin
         @(posedge clk);
         #2;
         if (rnd_on) memReady = 1'($urandom_range(0, 1));
      end
   end

   initial begin
      int k;
      // Reset state
      idle(2);
      rst = 1'b0;
      check("rst_valid", 64'(memValid), 64'd0);
      check("rst_count", 64'(writeCount), 64'd0);
      check("rst_done", 64'(done), 64'd0);
      check("rst_ovf", 64'(overflow), 64'd0);
      check("rst_late", 64'(lateWrite), 64'd0);

      // Four streamed writes with memReady high
      do_reset();
      memReady = 1'b1;
      check("pre_valid", 64'(memValid), 64'd0);
      for (int i = 0; i < 4; i++) begin
         wr(10'(i), 64'h1111_1111_1111_1111 * 64'(i + 1), 1'b1);
         if (i == 0) check("lat_valid", 64'(memValid), 64'd1);
      end
      idle(3);
      check("t1_count", 64'(writeCount), 64'd4);
      check("t1_valid", 64'(memValid), 64'd0);
      check("t1_drained", 64'(sb.size()), 64'd0);

      // Overflow with memReady low: 8 kept, 2 dropped
      do_reset();
      for (int i = 0; i < 10; i++) begin
         wr(10'(16 + i), 64'hA000_0000_0000_0000 + 64'(i), i < 8);
         if (i == 7) check("t2_no_ovf_8", 64'(overflow), 64'd0);
         if (i == 8) check("t2_ovf_9", 64'(overflow), 64'd1);
      end
      check("t2_valid_full", 64'(memValid), 64'd1);
      memReady = 1'b1;
      idle(10);
      check("t2_valid_end", 64'(memValid), 64'd0);
      check("t2_count", 64'(writeCount), 64'd8);
      check("t2_drained", 64'(sb.size()), 64'd0);

      // Full queue: simultaneous pop and push accepted, occupancy stays full
      do_reset();
      for (int i = 0; i < 8; i++) wr(10'(40 + i), 64'hB0B0_0000_0000_0000 + 64'(i), 1'b1);
      memReady = 1'b1;
      wr(10'd48, 64'hB0B0_0000_0000_0008, 1'b1);
      memReady = 1'b0;
      check("t3_no_ovf", 64'(overflow), 64'd0);
      wr(10'd49, 64'hB0B0_0000_0000_0009, 1'b0);
      check("t3_still_full", 64'(overflow), 64'd1);
      memReady = 1'b1;
      idle(12);
      check("t3_count", 64'(writeCount), 64'd9);
      check("t3_drained", 64'(sb.size()), 64'd0);

      // Reset mid-operation flushes queued words
      do_reset();
      for (int i = 0; i < 10; i++) wr(10'(200 + i), 64'hDEAD_0000_0000_0000 + 64'(i), i < 8);
      check("t4_pre_ovf", 64'(overflow), 64'd1);
      do_reset();
      check("t4_valid", 64'(memValid), 64'd0);
      check("t4_count", 64'(writeCount), 64'd0);
      check("t4_ovf", 64'(overflow), 64'd0);
      check("t4_late", 64'(lateWrite), 64'd0);
      check("t4_done", 64'(done), 64'd0);
      memReady = 1'b1;
      idle(5);
      check("t4_no_xfer", 64'(memValid), 64'd0);
      check("t4_count_after", 64'(writeCount), 64'd0);

      // 64 writes with random gaps and random memReady, then a late write
      do_reset();
      rnd_on = 1;
      for (int i = 0; i < 64; i++) begin
         wr(10'(300 + i), {16'(i), 16'(i * 3), 16'(i * 5), 16'(i * 7)}, 1'b1);
         idle(int'($urandom_range(2, 4)));
      end
      k = 0;
      while (sb.size() != 0 && k < 400) begin
         idle(1);
         k++;
      end
      rnd_on = 0;
      memReady = 1'b1;
      idle(2);
      check("t5_drained", 64'(sb.size()), 64'd0);
      check("t5_done", 64'(done), 64'd1);
      check("t5_count", 64'(writeCount), 64'd64);
      check("t5_no_ovf", 64'(overflow), 64'd0);
      wr(10'd999, 64'hFFFF_0000_FFFF_0000, 1'b0);
      check("t5_late", 64'(lateWrite), 64'd1);
      check("t5_late_no_ovf", 64'(overflow), 64'd0);
      idle(3);
      check("t5_no_xfer", 64'(memValid), 64'd0);
      check("t5_count_final", 64'(writeCount), 64'd64);
      check("t5_done_hold", 64'(done), 64'd1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/dram_write_buffer.md
# dram_write_buffer

Decoupling write-back stage directly downstream of the accelerator top level. Captures every max-pool result word the accelerator emits on its DRAM write port (enable/address/data, no backpressure) into a small first-word-fall-through queue. Drains the queue to a memory port with valid/ready handshake, counts completed writes and flags layer completion and overflow. Lets the accelerator run unstalled against a memory that can back-pressure.

## Interface

- `DEPTH`, 8, queue entries (power of two, ≥2)
- `EXPECTED_WRITES`, 64, completed memory writes that constitute one finished layer (1..1023)
- `clk`  in  1  single clock, all state updates on rising edge
- `rst`  in  1  reset; synchronous, active-high
- `DRAMwriteEn`  in  1  accelerator write strobe; one word per asserted cycle
- `DRAMwriteAddr`  in  10  accelerator write address
- `DRAMwriteData`  in  64  accelerator write data (four 16-bit pooled values)
- `memValid`  out  1  head entry is valid toward memory
- `memAddr`  out  10  head entry address
- `memData`  out  64  head entry data
- `memReady`  in  1  memory accepts head entry this cycle
- `writeCount`  out  10  memory writes completed since reset
- `done`  out  1  sticky; `writeCount` reached `EXPECTED_WRITES`
- `overflow`  out  1  sticky; an input word was dropped
- `lateWrite`  out  1  sticky; input word arrived while in DONE

## Operation

- Storage: `DEPTH` × 74-bit entries {addr[9:0], data[63:0]}; read pointer, write pointer, occupancy counter (log2(DEPTH)+1 bits).
- Pop: `pop = memValid & memReady`. Head entry retired; read pointer increments modulo `DEPTH`; `writeCount` increments.
- Push: `push = DRAMwriteEn & (occupancy < DEPTH | pop) & state != DONE`. Entry written at write pointer; pointer increments modulo `DEPTH`.
- Full with simultaneous pop: push accepted; occupancy unchanged (stays `DEPTH`).
- Full without pop and `DRAMwriteEn`: word dropped, `overflow` set. Pointers and occupancy unchanged.
- Empty with `DRAMwriteEn`: word enters queue; never bypasses to the output in the same cycle.
- Occupancy: `+1` on push only, `−1` on pop only, unchanged on both or neither.
- `memValid = (occupancy != 0)`. `memAddr`/`memData` driven from the head entry (FWFT). Values are don't-care when `memValid` = 0.
- FSM, 2-bit state:
  - IDLE: reset state. First accepted push → ACTIVE.
  - ACTIVE: normal push/pop. When a pop brings `writeCount` to `EXPECTED_WRITES` → DONE, on the same edge that `writeCount` updates.
  - DONE: `done` = 1. Pushes are blocked; any `DRAMwriteEn` sets `lateWrite`, and that word is dropped without setting `overflow`. Entries still queued continue to drain and `writeCount` keeps counting. Only `rst` exits DONE.
- `writeCount` saturates at 1023.
- Reset mid-operation flushes all queued entries; they are discarded and never written to memory.

## Timing

- Reset values: `memValid`=0, `writeCount`=0, `done`=0, `overflow`=0, `lateWrite`=0, state IDLE, pointers 0, occupancy 0. `memAddr`/`memData` are undefined but stable.
- Input-to-output latency is 1 cycle: a word pushed at edge N drives `memValid`/`memAddr`/`memData` after edge N (cycle N+1) when the queue was empty.
- Sustained throughput: 1 word/cycle in and out when `memReady` is held high. With an empty start, occupancy stays ≤1.
- Once `memValid` is high, `memAddr`/`memData` hold stable until `pop`. `memValid` does not drop without a pop.
- `done`, `overflow` and `lateWrite` rise on the edge of the triggering event and are registered outputs.
- All outputs are registered or decoded from registers only. There is no combinational path from `memReady` or `DRAMwriteEn` to any output.

## Test plan

- Reset, then 4 writes (addr 0..3, data 0x1111…×k) with `memReady`=1 → `memValid` first high the cycle after the first write; memory sees addr 0,1,2,3 in order with matching data; `writeCount`=4.
- `memReady`=0; 10 consecutive writes with `DEPTH`=8 → `overflow`=1 after the 9th write, occupancy 8. Raise `memReady` → exactly the first 8 words drain in order, then `memValid`=0.
- Queue full, `memReady`=1 and `DRAMwriteEn`=1 on the same cycle → new word accepted, `overflow` stays 0, occupancy stays 8.
- `EXPECTED_WRITES`=4; 4 writes drained → `done`=1 on the edge of the 4th pop. A 5th write → `lateWrite`=1, `overflow`=0, no memory transfer.
- 3 entries queued with `memReady`=0; assert `rst` for 1 cycle → `memValid`=0, `writeCount`=0, all flags 0; the old entries are never presented to memory.
- Random `memReady` (50% duty) with 64 writes at random gaps → memory sees all 64 in order, no overflow, `done`=1.
